// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock,
// start/busy/done handshake, overflow flag when the value exceeds DIGITS digits.
module result_bcd_converter #(
    parameter int unsigned N      = 8,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*N-1:0]        bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   adj;

    // Add-3 correction on every scratch digit in parallel before the shift.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    acc_d   = 1'b0;
                    cnt_d   = CW'(W);
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // Bit leaving the top digit carries weight 10^DIGITS: fold into overflow.
                scr_d = {adj[BW-2:0], bin_q[W-1]};
                bin_d = {bin_q[W-2:0], 1'b0};
                acc_d = acc_q | adj[BW-1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scr_d;
                    ovf_d   = acc_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench: a 5-digit and a 4-digit converter share stimulus; expected
// BCD values are hand-computed in the vector table and sequences below.
module tb_result_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int checks;
    int errors;

    result_bcd_converter #(.N(8), .DIGITS(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5)
    );

    result_bcd_converter #(.N(8), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd5;
        logic [15:0] bcd4;
        logic        ovf4;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; the request is sampled on the following posedge (E0).
    task automatic launch(input logic [15:0] b);
        start  = 1'b1;
        bin_in = b;
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~b;
    endtask

    // Waits for done (bounded) and checks latency, busy, and both results.
    task automatic finish_conv(input string name, input int lat0, input logic [19:0] e5,
                               input logic [15:0] e4, input logic eo4);
        int lat = lat0;
        int busy_lo = 0;
        while (!done5 && lat < 40) begin
            if (!busy5) busy_lo++;
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd16);
        chk({name, " busy_gap"}, 32'(busy_lo), 32'd0);
        chk({name, " busy_done_cycle"}, 32'(busy5), 32'd0);
        chk({name, " done4"}, 32'(done4), 32'd1);
        chk({name, " bcd5"}, 32'(bcd5), 32'(e5));
        chk({name, " ovf5"}, 32'(ovf5), 32'd0);
        chk({name, " bcd4"}, 32'(bcd4), 32'(e4));
        chk({name, " ovf4"}, 32'(ovf4), 32'(eo4));
    endtask

    initial begin
        int extra;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        bin_in = '0;
        rst_n  = 1'b0;

        vecs[0] = '{16'h0000, 20'h00000, 16'h0000, 1'b0};
        vecs[1] = '{16'hFE01, 20'h65025, 16'h5025, 1'b1};
        vecs[2] = '{16'h2710, 20'h10000, 16'h0000, 1'b1};
        vecs[3] = '{16'h270F, 20'h09999, 16'h9999, 1'b0};
        vecs[4] = '{16'h000A, 20'h00010, 16'h0010, 1'b0};
        vecs[5] = '{16'hEA5F, 20'h59999, 16'h9999, 1'b1};
        vecs[6] = '{16'h0001, 20'h00001, 16'h0001, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy5), 32'd0);
        chk("reset done", 32'(done5), 32'd0);
        chk("reset bcd5", 32'(bcd5), 32'd0);
        chk("reset ovf5", 32'(ovf5), 32'd0);
        chk("reset bcd4", 32'(bcd4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].bin);
            finish_conv($sformatf("vec%0d", i), 0, vecs[i].bcd5, vecs[i].bcd4, vecs[i].ovf4);
            @(negedge clk);
            chk($sformatf("vec%0d done_width", i), 32'(done5), 32'd0);
            chk($sformatf("vec%0d idle_busy", i), 32'(busy5), 32'd0);
        end

        // Back-to-back: new start accepted during the done cycle.
        launch(16'hFFFF);
        finish_conv("ffff", 0, 20'h65535, 16'h5535, 1'b1);
        launch(16'd9);
        chk("chain done_drop", 32'(done5), 32'd0);
        chk("chain busy", 32'(busy5), 32'd1);
        chk("chain bcd_hold", 32'(bcd5), 32'h65535);
        finish_conv("chain9", 0, 20'h00009, 16'h0009, 1'b0);
        @(negedge clk);

        // Start while busy is ignored.
        launch(16'd1234);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 16'h10E1;
        @(negedge clk);
        start  = 1'b0;
        finish_conv("ignore", 5, 20'h01234, 16'h1234, 1'b0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done5) extra++;
        end
        chk("ignore extra_done", 32'(extra), 32'd0);
        chk("ignore bcd_hold", 32'(bcd5), 32'h01234);

        // Asynchronous reset mid-conversion.
        launch(16'd500);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy5), 32'd0);
        chk("abort done", 32'(done5), 32'd0);
        chk("abort bcd5", 32'(bcd5), 32'd0);
        chk("abort ovf", 32'(ovf5), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done5 || busy5) extra++;
        end
        chk("abort no_done", 32'(extra), 32'd0);
        chk("abort bcd_zero", 32'(bcd5), 32'd0);
        launch(16'd42);
        finish_conv("after_abort", 0, 20'h00042, 16'h0042, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
Sequential double-dabble converter that sits directly downstream of the multiply/divide datapath. It consumes the 2N-bit unsigned result and produces packed BCD digits for the calculator display stage. It uses a start/busy/done handshake and takes one shift per clock, so there is no wide combinational divide-by-10 logic.

Parameters:
N, 8, operand width of the upstream datapath; the converter input is 2N bits wide.
DIGITS, 5, number of BCD output digits; 5 digits cover the full 16-bit range at N=8.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to convert bin_in; sampled only while busy=0
bin_in  input  2N  unsigned binary result from the multiply/divide stage
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when bcd_out/overflow update
bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]
overflow  output  1  value exceeded 10^DIGITS-1; bcd_out then holds value mod 10^DIGITS

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, bcd_out=0, overflow=0.
  - Internal shift register, scratch BCD, counter and overflow accumulator are all cleared.
- Reset mid-conversion aborts the conversion immediately. No done pulse is produced, and bcd_out stays 0.
- FSM states: IDLE, CONVERT.
- IDLE:
  - If start=1 at edge E0: latch bin_in into the binary shift register, clear scratch BCD and the overflow accumulator, load counter=2N, set busy=1, go to CONVERT.
  - Changes on bin_in after E0 have no effect on the current conversion.
- CONVERT, each edge:
  - For each scratch digit, add 3 if the digit is >=5; all digits are adjusted in parallel.
  - Shift {adjusted scratch, binary reg} left by one.
  - OR the bit shifted out of the top digit into the overflow accumulator.
  - Decrement the counter.
- Completion, on the edge that performs the 2N-th shift (E_2N):
  - bcd_out <= final scratch; overflow <= accumulator.
  - done <= 1 and busy <= 0; state returns to IDLE.
- done is high for exactly one cycle, then returns to 0.
- Latency: start sampled at E0 gives done high in the cycle following E_2N, which is 2N clocks later and independent of DIGITS. This is 16 clocks at N=8.
- start while busy=1 is ignored: no queuing, and the current conversion is unaffected.
- start high during the done cycle (busy=0) is accepted. The new conversion begins, that done pulse still completes normally, and bcd_out holds the old result until the next completion.
- bcd_out and overflow hold their last values between completions.
- Arithmetic:
  - Adjusted digits never exceed 12 before the shift.
  - If DIGITS*4 < the bits needed for 2^(2N)-1, overflow flags correctly and bcd_out = value mod 10^DIGITS.
- Zero input is a normal conversion: full 2N-cycle latency, bcd_out=0, overflow=0.

Test Plan:
1. Reset, then start with bin_in=16'h0000 (N=8, DIGITS=5) -> done pulses exactly 16 clocks after the start edge; bcd_out=20'h00000, overflow=0.
2. bin_in=16'hFE01 (255*255, the upstream maximum product) -> bcd_out=20'h65025, overflow=0; busy high for exactly 16 cycles, done high for exactly 1.
3. bin_in=16'hFFFF -> bcd_out=20'h65535. Then start with bin_in=16'd9 held on the done cycle -> accepted; second done 16 clocks later with bcd_out=20'h00009.
4. DIGITS=4, bin_in=16'd10000 -> overflow=1, bcd_out=16'h0000. Then bin_in=16'd9999 -> overflow=0, bcd_out=16'h9999.
5. Start with 16'd1234, pulse start again with 16'd4321 at cycle 5 while busy -> second request ignored; single done with bcd_out=20'h01234.
6. Start with 16'd500, assert rst_n=0 asynchronously at cycle 8 (between edges) -> busy, done, bcd_out and overflow go to 0 immediately; no done pulse after release. A fresh start with 16'd42 then gives bcd_out=20'h00042.
